alien_formation_renderer: RTL and testbench

ALIEN_FORMATION_RENDERER -- requirements
Module: alien_formation_renderer

---
 rtl/invaders_pkg.sv | 29 ++
 rtl/alien_march_fsm.sv | 87 ++++++++
 rtl/alien_formation_renderer.sv | 93 +++++++++
 tb/tb_alien_formation_renderer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared formation geometry and march FSM encodings for the alien formation logic.
package invaders_pkg;

    localparam int PITCH     = 32;
    localparam int SCALE     = 2;
    localparam int COLS      = 8;
    localparam int ROWS      = 3;
    localparam int SPRITE    = 10;
    localparam int SPRITE_PX = SPRITE * SCALE;
    localparam int WIDTH     = (COLS - 1) * PITCH + SPRITE_PX;
    localparam int HEIGHT    = (ROWS - 1) * PITCH + SPRITE_PX;

    typedef enum logic [1:0] {
        MOVE_R = 2'd0,
        MOVE_L = 2'd1,
        DROP   = 2'd2
    } march_state_t;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } march_dir_t;

    // Row-major position of an alien inside the 24-bit alive mask.
    function automatic logic [4:0] alive_index(input logic [1:0] row, input logic [2:0] col);
        return {row, 3'b000} + {2'b00, col};
    endfunction

endpackage

// File: rtl/alien_march_fsm.sv
// March FSM: steps the formation sideways, drops at the edges, freezes on invasion.
module alien_march_fsm
    import invaders_pkg::*;
#(
    parameter int MOVE_DIV = 4,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 8,
    parameter int X_MIN    = 16,
    parameter int X_MAX    = 380,
    parameter int Y_START  = 40,
    parameter int Y_LIMIT  = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    output logic [9:0] formation_x,
    output logic [9:0] formation_y,
    output logic       reached_bottom
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    march_state_t   state, state_next;
    march_dir_t     next_dir, dir_next;
    logic [CW-1:0]  frame_cnt;
    logic [9:0]     x_next, y_next;
    logic           move_event;
    logic           bottom_next;

    assign move_event = frame_tick && (frame_cnt == CW'(MOVE_DIV - 1));

    always_comb begin
        state_next = state;
        dir_next   = next_dir;
        x_next     = formation_x;
        y_next     = formation_y;
        if (move_event && !reached_bottom) begin
            case (state)
                MOVE_R: begin
                    if (formation_x >= 10'(X_MAX)) begin
                        state_next = DROP;
                        dir_next   = DIR_L;
                    end else begin
                        x_next = formation_x + 10'(STEP_X);
                    end
                end
                MOVE_L: begin
                    if (formation_x <= 10'(X_MIN)) begin
                        state_next = DROP;
                        dir_next   = DIR_R;
                    end else begin
                        x_next = formation_x - 10'(STEP_X);
                    end
                end
                DROP: begin
                    y_next     = formation_y + 10'(STEP_Y);
                    state_next = (next_dir == DIR_L) ? MOVE_L : MOVE_R;
                end
                default: state_next = MOVE_R;
            endcase
        end
    end

    // Evaluated on the updated y so the flag rises on the same edge as the fatal drop.
    assign bottom_next = reached_bottom ||
                         (({1'b0, y_next} + 11'(HEIGHT)) >= 11'(Y_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= MOVE_R;
            next_dir       <= DIR_L;
            frame_cnt      <= '0;
            formation_x    <= 10'(X_MIN);
            formation_y    <= 10'(Y_START);
            reached_bottom <= 1'b0;
        end else begin
            if (frame_tick)
                frame_cnt <= move_event ? '0 : frame_cnt + 1'b1;
            state          <= state_next;
            next_dir       <= dir_next;
            formation_x    <= x_next;
            formation_y    <= y_next;
            reached_bottom <= bottom_next;
        end
    end

endmodule

// File: rtl/alien_formation_renderer.sv
// Renders the 8x3 alien formation per pixel and tracks which aliens are still alive.
module alien_formation_renderer
    import invaders_pkg::*;
#(
    parameter int MOVE_DIV = 4,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 8,
    parameter int X_MIN    = 16,
    parameter int X_MAX    = 380,
    parameter int Y_START  = 40,
    parameter int Y_LIMIT  = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       video_active,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [3:0] rom_row_index,
    input  logic [9:0] rom_row_data,
    input  logic       kill_valid,
    input  logic [2:0] kill_col,
    input  logic [1:0] kill_row,
    output logic       alien_pixel,
    output logic [9:0] formation_x,
    output logic [9:0] formation_y,
    output logic       all_dead,
    output logic       reached_bottom
);

    logic [9:0]  rel_x, rel_y;
    logic        hit;
    logic [2:0]  col;
    logic [1:0]  row;
    logic [3:0]  sx;
    logic        sprite_bit;
    logic        pixel_next;
    logic [23:0] alive, alive_next;
    logic [4:0]  kill_idx;

    alien_march_fsm #(
        .MOVE_DIV (MOVE_DIV),
        .STEP_X   (STEP_X),
        .STEP_Y   (STEP_Y),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .Y_START  (Y_START),
        .Y_LIMIT  (Y_LIMIT)
    ) u_march (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .formation_x    (formation_x),
        .formation_y    (formation_y),
        .reached_bottom (reached_bottom)
    );

    // Pixels left of / above the formation wrap to large values and miss the range test.
    assign rel_x = pix_x - formation_x;
    assign rel_y = pix_y - formation_y;

    assign hit = (rel_x < 10'(COLS * PITCH)) && (rel_y < 10'(ROWS * PITCH)) &&
                 (rel_x[4:0] < 5'(SPRITE_PX)) && (rel_y[4:0] < 5'(SPRITE_PX)) &&
                 (rel_y[6:5] < 2'(ROWS));

    assign col           = rel_x[7:5];
    assign row           = rel_y[6:5];
    assign sx            = rel_x[4:1];
    assign rom_row_index = hit ? rel_y[4:1] : 4'd0;
    assign sprite_bit    = (sx <= 4'd9) ? rom_row_data[4'd9 - sx] : 1'b0;
    assign pixel_next    = video_active && hit && alive[alive_index(row, col)] && sprite_bit;

    assign kill_idx = alive_index(kill_row, kill_col);

    always_comb begin
        alive_next = alive;
        if (kill_valid && (kill_row != 2'd3))
            alive_next[kill_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alive       <= 24'hFFFFFF;
            all_dead    <= 1'b0;
            alien_pixel <= 1'b0;
        end else begin
            alive       <= alive_next;
            all_dead    <= (alive_next == 24'd0);
            alien_pixel <= pixel_next;
        end
    end

endmodule

// File: tb/tb_alien_formation_renderer.sv
// Scoreboard bench for alien_formation_renderer with its own sprite ROM and march model.
module tb_alien_formation_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       video_active = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [3:0] rom_row_index;
    logic [9:0] rom_row_data;
    logic       kill_valid = 1'b0;
    logic [2:0] kill_col = '0;
    logic [1:0] kill_row = '0;
    logic       alien_pixel;
    logic [9:0] formation_x;
    logic [9:0] formation_y;
    logic       all_dead;
    logic       reached_bottom;

    int vectors = 0;
    int miscompares = 0;

    // Reference state of the march and alive mask
    int          mx, my, mcnt;
    bit          mdir_l, mnext_l, mdrop, mbottom;
    logic [23:0] alive_m;
    bit          exp_q[$];

    always #5 clk = ~clk;

    alien_formation_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .video_active   (video_active),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .rom_row_index  (rom_row_index),
        .rom_row_data   (rom_row_data),
        .kill_valid     (kill_valid),
        .kill_col       (kill_col),
        .kill_row       (kill_row),
        .alien_pixel    (alien_pixel),
        .formation_x    (formation_x),
        .formation_y    (formation_y),
        .all_dead       (all_dead),
        .reached_bottom (reached_bottom)
    );

    function automatic logic [9:0] sprite_rom(input int r);
        case (r)
            0: return 10'b0011111100;
            1: return 10'b0111111110;
            2: return 10'b1101111011;
            3: return 10'b1111111111;
            4: return 10'b1011111101;
            5: return 10'b0010000100;
            6: return 10'b0100110010;
            7: return 10'b1000000001;
            8: return 10'b0110000110;
            9: return 10'b0001111000;
            default: return 10'b0;
        endcase
    endfunction

    assign rom_row_data = sprite_rom(int'(rom_row_index));

    task automatic checkOutput(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Geometric hit test done with signed integer division rather than bit slicing.
    function automatic bit ref_hit(input int px, input int py, output int c, output int r,
                                   output int ox, output int oy);
        int dx, dy;
        dx = px - mx;
        dy = py - my;
        c = 0; r = 0; ox = 0; oy = 0;
        if (dx < 0 || dy < 0 || dx >= 256 || dy >= 96) return 0;
        c  = dx / 32;
        r  = dy / 32;
        ox = dx % 32;
        oy = dy % 32;
        return (ox < 20) && (oy < 20) && (r < 3);
    endfunction

    task automatic applyStimulus(input int px, input int py, input bit va);
        int c, r, ox, oy;
        bit h, e;
        logic [9:0] rowbits;
        h = ref_hit(px, py, c, r, ox, oy);
        rowbits = sprite_rom(oy / 2);
        e = va && h && alive_m[r * 8 + c] && rowbits[9 - ox / 2];
        @(negedge clk);
        pix_x = 10'(px);
        pix_y = 10'(py);
        video_active = va;
        #1;
        checkOutput("rom_row_index", rom_row_index, h ? oy / 2 : 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) checkOutput("scoreboard_empty", 1, 0);
        else checkOutput("alien_pixel", alien_pixel, exp_q.pop_front());
    endtask

    function automatic bit modelTick();
        if (mbottom) return 0;
        mcnt = (mcnt + 1) % 4;
        if (mcnt != 0) return 0;
        if (mdrop) begin
            my += 8;
            mdrop = 0;
            mdir_l = mnext_l;
        end else if (!mdir_l) begin
            if (mx >= 380) begin mdrop = 1; mnext_l = 1; end
            else mx += 4;
        end else begin
            if (mx <= 16) begin mdrop = 1; mnext_l = 0; end
            else mx -= 4;
        end
        if (my + 84 >= 400) mbottom = 1;
        return 1;
    endfunction

    task automatic tickFrame(input bit kv, input int kc, input int kr, output bit moved);
        @(negedge clk);
        frame_tick = 1'b1;
        kill_valid = kv;
        kill_col   = 3'(kc);
        kill_row   = 2'(kr);
        @(negedge clk);
        frame_tick = 1'b0;
        kill_valid = 1'b0;
        moved = modelTick();
        if (kv && kr != 3) alive_m[kr * 8 + kc] = 1'b0;
    endtask

    task automatic killAlien(input int kc, input int kr);
        @(negedge clk);
        kill_valid = 1'b1;
        kill_col   = 3'(kc);
        kill_row   = 2'(kr);
        @(negedge clk);
        kill_valid = 1'b0;
        if (kr != 3) alive_m[kr * 8 + kc] = 1'b0;
    endtask

    task automatic modelReset();
        mx = 16; my = 40; mcnt = 0;
        mdir_l = 0; mnext_l = 1; mdrop = 0; mbottom = 0;
        alive_m = 24'hFFFFFF;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        bit moved;
        int guard;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_x", formation_x, 16);
        checkOutput("reset_y", formation_y, 40);
        checkOutput("reset_pixel", alien_pixel, 0);
        checkOutput("reset_all_dead", all_dead, 0);
        checkOutput("reset_bottom", reached_bottom, 0);

        applyStimulus(16, 40, 1);
        applyStimulus(20, 40, 1);
        applyStimulus(36, 40, 1);
        applyStimulus(20, 40, 0);
        applyStimulus(54, 62, 1);
        applyStimulus(60, 76, 1);
        applyStimulus(250, 106, 1);
        applyStimulus(10, 40, 1);
        applyStimulus(16, 140, 1);
        for (int i = 0; i < 24; i++)
            applyStimulus(int'($urandom_range(0, 300)), int'($urandom_range(30, 150)), 1);

        killAlien(0, 0);
        applyStimulus(20, 40, 1);
        killAlien(0, 0);
        killAlien(1, 3);
        applyStimulus(54, 40, 1);
        checkOutput("all_dead_partial", all_dead, 0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                killAlien(c, r);
        @(posedge clk);
        #1;
        checkOutput("all_dead", all_dead, 1);
        applyStimulus(116, 104, 1);

        doReset();
        for (int t = 0; t < 364; t++)
            tickFrame(t == 100, 2, 1, moved);
        checkOutput("edge_x", formation_x, 380);
        checkOutput("edge_y", formation_y, 40);
        applyStimulus(380 + 64 + 4, 40 + 32 + 4, 1);
        applyStimulus(380 + 96 + 4, 40 + 32 + 4, 1);
        for (int t = 0; t < 4; t++) tickFrame(0, 0, 0, moved);
        checkOutput("drop_x", formation_x, 380);
        checkOutput("drop_y", formation_y, 40);
        for (int t = 0; t < 4; t++) tickFrame(0, 0, 0, moved);
        checkOutput("after_drop_x", formation_x, 380);
        checkOutput("after_drop_y", formation_y, 48);
        for (int t = 0; t < 4; t++) tickFrame(0, 0, 0, moved);
        checkOutput("move_left_x", formation_x, 376);

        guard = 0;
        while (!mbottom && guard < 20000) begin
            tickFrame(0, 0, 0, moved);
            if (moved && mdrop) checkOutput("march_x", formation_x, mx);
            if (moved && !mdrop && mcnt == 0 && formation_y != 10'(my))
                checkOutput("march_y", formation_y, my);
            guard++;
        end
        if (!mbottom) checkOutput("bottom_timeout", 0, 1);
        checkOutput("bottom_y", formation_y, 320);
        checkOutput("bottom_flag", reached_bottom, 1);
        for (int t = 0; t < 8; t++) tickFrame(0, 0, 0, moved);
        checkOutput("frozen_x", formation_x, mx);
        checkOutput("frozen_y", formation_y, 320);
        checkOutput("frozen_flag", reached_bottom, 1);

        doReset();
        for (int t = 0; t < 184; t++) tickFrame(0, 0, 0, moved);
        checkOutput("mid_x", formation_x, 200);
        killAlien(3, 2);
        applyStimulus(204, 40, 1);
        @(negedge clk);
        reset = 1'b1;
        frame_tick = 1'b1;
        kill_valid = 1'b1;
        kill_col = 3'd0;
        kill_row = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        frame_tick = 1'b0;
        kill_valid = 1'b0;
        modelReset();
        checkOutput("rst_x", formation_x, 16);
        checkOutput("rst_y", formation_y, 40);
        checkOutput("rst_pixel", alien_pixel, 0);
        checkOutput("rst_all_dead", all_dead, 0);
        applyStimulus(20, 40, 1);
        applyStimulus(116, 104, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
